// File: rtl/feedback_pkg.sv
// feedback_pkg: shared constants and FSM encoding for the GenshinKitchen feedback decoder
package feedback_pkg;
   localparam logic [1:0] FB_TYPE = 2'b01;
   localparam int FB_PLAYER_READY    = 0;
   localparam int FB_PLAYER_HAS_ITEM = 1;
   localparam int FB_TARGET_READY    = 2;
   localparam int FB_TARGET_HAS_ITEM = 3;
   localparam int FB_TARGET_BUSY     = 4;
   localparam int FB_GAME_RUNNING    = 5;
   typedef enum logic [1:0] {SYNC = 2'd0, LIVE = 2'd1, STALE = 2'd2} fb_state_t;
endpackage

// File: rtl/feedback_filter.sv
// feedback_filter: commits a payload once it has been seen FILTER_DEPTH times in a row
module feedback_filter #(
   parameter int FILTER_DEPTH = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_fb,
   input  logic [5:0] i_payload,
   output logic       o_commit
);
   localparam logic [3:0] DEPTH = 4'(FILTER_DEPTH);
   logic [5:0] r_cand;
   logic [3:0] r_cnt;
   logic       w_match;
   logic [3:0] w_next_cnt;
   assign w_match    = (i_payload == r_cand) && (r_cnt != 4'd0);
   // count saturates at DEPTH so a steady stream keeps re-committing
   assign w_next_cnt = !w_match ? 4'd1 : (r_cnt == DEPTH) ? DEPTH : r_cnt + 4'd1;
   assign o_commit   = i_fb && (w_next_cnt == DEPTH);
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cand <= '0;
         r_cnt  <= '0;
      end else if (i_fb) begin
         r_cand <= i_payload;
         r_cnt  <= w_next_cnt;
      end
   end
endmodule

// File: rtl/feedback_decoder.sv
// feedback_decoder: turns UART feedback bytes into a filtered, timed-out 6-bit status vector
module feedback_decoder
   import feedback_pkg::*;
#(
   parameter int FILTER_DEPTH   = 2,
   parameter int TIMEOUT_CYCLES = 153600,
   parameter int CNT_W          = 18
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data_bits,
   input  logic       data_valid,
   input  logic       script_mode,
   output logic [5:0] flags,
   output logic       flags_valid,
   output logic [5:0] rise_pulse,
   output logic [5:0] fall_pulse,
   output logic       stale,
   output logic [7:0] err_count
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   fb_state_t        r_state, w_next_state;
   logic [CNT_W-1:0] r_tcnt;
   logic [5:0]       r_flags, r_rise, r_fall;
   logic [7:0]       r_err;
   logic             w_acc, w_fb, w_err, w_commit, w_expire;
   logic [5:0]       w_payload;
   assign w_payload = data_bits[7:2];
   assign w_acc     = data_valid && !script_mode;
   assign w_fb      = w_acc && (data_bits[1:0] == FB_TYPE);
   assign w_err     = w_acc && (data_bits[1:0] != FB_TYPE);
   // an accepted feedback byte in the expiry cycle keeps the link live
   assign w_expire  = (r_state == LIVE) && !script_mode && !w_fb && (r_tcnt == LAST);
   feedback_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filter (
      .clock     (clock),
      .reset     (reset),
      .i_fb      (w_fb),
      .i_payload (w_payload),
      .o_commit  (w_commit)
   );
   always_comb begin
      w_next_state = r_state;
      if (w_commit) w_next_state = LIVE;
      else if (w_expire) w_next_state = STALE;
   end
   always_ff @(posedge clock) begin
      if (reset) r_state <= SYNC;
      else r_state <= w_next_state;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_flags <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
         r_err   <= '0;
         r_tcnt  <= '0;
      end else begin
         r_rise <= w_commit ? (w_payload & ~r_flags) : '0;
         r_fall <= w_commit ? (~w_payload & r_flags) : '0;
         if (w_commit) r_flags <= w_payload;
         if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
         r_tcnt <= (w_fb || w_expire) ? '0 : (r_state == LIVE && !script_mode) ? r_tcnt + 1'b1 : r_tcnt;
      end
   end
   assign flags       = r_flags;
   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign err_count   = r_err;
   assign flags_valid = (r_state == LIVE);
   assign stale       = (r_state == STALE);
endmodule

// File: tb/tb_feedback_decoder.sv
// tb_feedback_decoder: directed scoreboard bench for feedback_decoder (short timeout build)
module tb_feedback_decoder;
   localparam int TO = 40;
   typedef struct packed {
      logic [5:0] flags;
      logic       fv;
      logic [5:0] rise;
      logic [5:0] fall;
      logic       stale;
      logic [7:0] err;
   } exp_t;
   logic       clock = 0, reset = 1, data_valid = 0, script_mode = 0;
   logic [7:0] data_bits = 0;
   logic [5:0] flags, rise_pulse, fall_pulse;
   logic       flags_valid, stale;
   logic [7:0] err_count;
   exp_t       sb[$];
   int         tests = 0, fails = 0;
   feedback_decoder #(.FILTER_DEPTH(2), .TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .data_bits(data_bits), .data_valid(data_valid),
      .script_mode(script_mode), .flags(flags), .flags_valid(flags_valid),
      .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .stale(stale), .err_count(err_count)
   );
   always #5 clock = ~clock;
   function automatic exp_t E(logic [5:0] f, logic v, logic [5:0] r, logic [5:0] fl, logic s, logic [7:0] e);
      return '{flags: f, fv: v, rise: r, fall: fl, stale: s, err: e};
   endfunction
   task automatic cmp(input string tag, input string fld, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s %s got %h expected %h", tag, fld, got, exp);
      end
   endtask
   task automatic check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      cmp(tag, "flags", {2'b0, flags}, {2'b0, e.flags});
      cmp(tag, "flags_valid", {7'b0, flags_valid}, {7'b0, e.fv});
      cmp(tag, "rise", {2'b0, rise_pulse}, {2'b0, e.rise});
      cmp(tag, "fall", {2'b0, fall_pulse}, {2'b0, e.fall});
      cmp(tag, "stale", {7'b0, stale}, {7'b0, e.stale});
      cmp(tag, "err", err_count, e.err);
   endtask
   task automatic send(input logic rv, input logic sm, input logic [7:0] b);
      @(negedge clock);
      reset = rv; data_valid = 1; script_mode = sm; data_bits = b;
      @(posedge clock);
      #1;
      data_valid = 0; reset = 0;
   endtask
   task automatic step(input logic rv, input logic dv, input logic sm, input logic [7:0] b, input exp_t e, input string tag);
      @(negedge clock);
      reset = rv; data_valid = dv; script_mode = sm; data_bits = b;
      sb.push_back(e);
      @(posedge clock);
      #1;
      data_valid = 0; reset = 0;
      check(tag);
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic expect_now(input exp_t e, input string tag);
      sb.push_back(e);
      check(tag);
   endtask
   initial begin
      step(1, 0, 0, 8'h00, E(0, 0, 0, 0, 0, 0), "reset0");
      step(1, 0, 0, 8'h00, E(0, 0, 0, 0, 0, 0), "reset1");
      step(0, 1, 0, 8'h85, E(0, 0, 0, 0, 0, 0), "first85");
      step(0, 1, 0, 8'h85, E(6'h21, 1, 6'h21, 0, 0, 0), "commit21");
      step(0, 0, 0, 8'h00, E(6'h21, 1, 0, 0, 0, 0), "pulse_clear");
      step(0, 1, 0, 8'h0D, E(6'h21, 1, 0, 0, 0, 0), "single0D");
      step(0, 1, 0, 8'h09, E(6'h21, 1, 0, 0, 0, 0), "first09");
      step(0, 1, 0, 8'h09, E(6'h02, 1, 6'h02, 6'h21, 0, 0), "commit02");
      step(0, 1, 0, 8'h09, E(6'h02, 1, 0, 0, 0, 0), "recommit02");
      idle(TO - 1);
      expect_now(E(6'h02, 1, 0, 0, 0, 0), "before_expiry");
      idle(1);
      expect_now(E(6'h02, 0, 0, 0, 1, 0), "stale");
      step(0, 1, 0, 8'h09, E(6'h02, 1, 0, 0, 0, 0), "relive_a");
      step(0, 1, 0, 8'h09, E(6'h02, 1, 0, 0, 0, 0), "relive_b");
      idle(TO - 1);
      step(0, 1, 0, 8'h09, E(6'h02, 1, 0, 0, 0, 0), "byte_at_expiry");
      idle(TO - 1);
      expect_now(E(6'h02, 1, 0, 0, 0, 0), "counter_cleared");
      idle(1);
      expect_now(E(6'h02, 0, 0, 0, 1, 0), "stale2");
      step(0, 1, 0, 8'h85, E(6'h02, 0, 0, 0, 1, 0), "stale_first85");
      step(0, 1, 0, 8'h85, E(6'h21, 1, 6'h21, 6'h02, 0, 0), "stale_commit21");
      step(0, 1, 1, 8'h00, E(6'h21, 1, 0, 0, 0, 0), "script00");
      step(0, 1, 1, 8'h85, E(6'h21, 1, 0, 0, 0, 0), "script85a");
      step(0, 1, 1, 8'h85, E(6'h21, 1, 0, 0, 0, 0), "script85b");
      step(0, 1, 0, 8'h09, E(6'h21, 1, 0, 0, 0, 0), "resume09a");
      step(0, 1, 1, 8'h0D, E(6'h21, 1, 0, 0, 0, 0), "script0D");
      step(0, 1, 0, 8'h09, E(6'h02, 1, 6'h02, 6'h21, 0, 0), "resume09b");
      step(0, 1, 0, 8'hFF, E(6'h02, 1, 0, 0, 0, 1), "errFF");
      step(0, 1, 0, 8'h02, E(6'h02, 1, 0, 0, 0, 2), "err02");
      for (int i = 0; i < 252; i++) send(0, 0, 8'h02);
      expect_now(E(6'h02, 0, 0, 0, 1, 254), "err254");
      step(0, 1, 0, 8'h02, E(6'h02, 0, 0, 0, 1, 255), "err255");
      for (int i = 0; i < 47; i++) send(0, 0, 8'h02);
      expect_now(E(6'h02, 0, 0, 0, 1, 255), "err_sat");
      step(0, 1, 0, 8'h85, E(6'h02, 0, 0, 0, 1, 255), "pre_rst85");
      step(0, 1, 0, 8'h85, E(6'h21, 1, 6'h21, 6'h02, 0, 255), "pre_rst_commit");
      step(1, 0, 0, 8'h00, E(0, 0, 0, 0, 0, 0), "rst_after_commit");
      step(0, 1, 0, 8'h85, E(0, 0, 0, 0, 0, 0), "post_rst85");
      step(1, 1, 0, 8'h85, E(0, 0, 0, 0, 0, 0), "rst_with_commit");
      step(0, 1, 0, 8'h85, E(0, 0, 0, 0, 0, 0), "filter_was_reset");
      step(0, 1, 0, 8'h85, E(6'h21, 1, 6'h21, 0, 0, 0), "final_commit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
